// File: rtl/wb_mailbox.sv
// Wishbone mailbox: EC-side register window onto a TX FIFO (EC to host) and an
// RX FIFO (host to EC), plus a registered active-low host interrupt.
module wb_mailbox #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic        stb_i,
    input  logic        cyc_i,
    output logic        ack_o,
    input  logic        h_wr,
    input  logic [31:0] h_wdat,
    input  logic        h_rd,
    output logic [31:0] h_rdat,
    output logic        h_full,
    output logic        h_empty,
    output logic        h_nint
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         CntFull = CW'(DEPTH);
    localparam logic [CW-1:0]         CntOne  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        RegTxData = 2'd0,
        RegRxData = 2'd1,
        RegStatus = 2'd2,
        RegIrqEn  = 2'd3
    } reg_e;

    logic [31:0] tx_mem [DEPTH];
    logic [31:0] rx_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic                  tx_ovf_q, tx_ovf_d;
    logic                  ack_q, nint_q;
    logic [1:0]            irqen_q;
    logic [31:0]           dat_q, rdata, status;

    logic acc, full_word;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push_req, tx_push, tx_pop;
    logic rx_pop_req, rx_pop, rx_push;
    reg_e reg_sel;

    logic unused_adr;
    assign unused_adr = ^{adr_i[5:4], adr_i[1:0]};

    assign acc       = stb_i & cyc_i & ~ack_q;
    assign reg_sel   = reg_e'(adr_i[3:2]);
    assign full_word = (sel_i == 4'hF);

    assign tx_full  = (tx_cnt_q == CntFull);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CntFull);
    assign rx_empty = (rx_cnt_q == '0);

    // A pop on a full FIFO frees the slot for a push on the same edge.
    assign tx_push_req = acc & we_i & full_word & (reg_sel == RegTxData);
    assign tx_pop      = h_rd & ~tx_empty;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);

    assign rx_pop_req = acc & ~we_i & full_word & (reg_sel == RegRxData);
    assign rx_pop     = rx_pop_req & ~rx_empty;
    assign rx_push    = h_wr & (~rx_full | rx_pop);

    assign status = {8'h00, 8'(rx_cnt_q), 7'h00, tx_ovf_q, 4'h0,
                     tx_full, tx_empty, rx_full, rx_empty};

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            RegTxData: rdata = '0;
            RegRxData: rdata = (full_word && !rx_empty) ? rx_mem[rx_rp_q] : '0;
            RegStatus: rdata = status;
            RegIrqEn:  rdata = {30'h0, irqen_q};
        endcase
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CntOne;
        end else if (!tx_push && tx_pop) begin
            tx_cnt_d = tx_cnt_q - CntOne;
        end
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + CntOne;
        end else if (!rx_push && rx_pop) begin
            rx_cnt_d = rx_cnt_q - CntOne;
        end
        // Overflow is sticky until software reads STATUS.
        tx_ovf_d = tx_ovf_q;
        if (acc && !we_i && reg_sel == RegStatus) begin
            tx_ovf_d = 1'b0;
        end else if (tx_push_req && !tx_push) begin
            tx_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irqen_q  <= '0;
            tx_ovf_q <= 1'b0;
            nint_q   <= 1'b1;
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            ack_q    <= acc;
            tx_ovf_q <= tx_ovf_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            if (acc) begin
                dat_q <= we_i ? '0 : rdata;
            end
            if (acc && we_i && reg_sel == RegIrqEn) begin
                irqen_q <= dat_i[1:0];
            end
            if (tx_push) tx_wp_q <= tx_wp_q + PtrOne;
            if (tx_pop)  tx_rp_q <= tx_rp_q + PtrOne;
            if (rx_push) rx_wp_q <= rx_wp_q + PtrOne;
            if (rx_pop)  rx_rp_q <= rx_rp_q + PtrOne;
            nint_q <= ~((irqen_q[0] & ~rx_empty) | (irqen_q[1] & ~tx_full));
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= dat_i;
        if (rx_push) rx_mem[rx_wp_q] <= h_wdat;
    end

    assign dat_o   = dat_q;
    assign ack_o   = ack_q;
    assign h_rdat  = tx_mem[tx_rp_q];
    assign h_full  = rx_full;
    assign h_empty = tx_empty;
    assign h_nint  = nint_q;
endmodule

// File: doc/wb_mailbox.md
WB_MAILBOX -- requirements
Module: wb_mailbox

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, log2 of entries in each FIFO (DEPTH = 16).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 adr_i  input  6  Wishbone byte address; register select = adr_i[3:2], other bits ignored.
REQ-005 dat_i  input  32  Wishbone write data.
REQ-006 dat_o  output  32  Wishbone read data, registered.
REQ-007 we_i  input  1  Wishbone write enable.
REQ-008 sel_i  input  4  byte selects; data registers require sel_i=4'hF, else access acks with no side effect.
REQ-009 stb_i, cyc_i  input  1 each  Wishbone strobe and cycle.
REQ-010 ack_o  output  1  Wishbone acknowledge.
REQ-011 h_wr  input  1  host push into RX FIFO (host-to-EC).
REQ-012 h_wdat  input  32  host push data.
REQ-013 h_rd  input  1  host pop from TX FIFO (EC-to-host).
REQ-014 h_rdat  output  32  TX FIFO head word, valid when h_empty=0 (show-ahead).
REQ-015 h_full  output  1  RX FIFO full.
REQ-016 h_empty  output  1  TX FIFO empty.
REQ-017 h_nint  output  1  active-low interrupt to host, registered.

Function
REQ-018 Registers (adr_i[3:2]): 0 TXDATA (W: push TX; R: returns 0), 1 RXDATA (R: pop RX; W: ignored), 2 STATUS (R only), 3 IRQEN (R/W, bits [1:0]).
REQ-019 STATUS = {16'b0, rx_count[7:0], 4'b0, tx_full, tx_empty, rx_full, rx_empty}; counts zero-extended.
REQ-020 Access accepted on edge where stb_i & cyc_i & !ack_o; side effects and dat_o load on that edge; ack_o high exactly next cycle.
REQ-021 ack_o single-cycle pulse; back-to-back strobe gives ack every other cycle; latency 1 cycle.
REQ-022 stb_i dropped before ack: no further effect; access already committed.
REQ-023 TXDATA write when TX full: data dropped, ack still given, sticky tx_ovf set (IRQEN-independent, visible STATUS bit 8 -- overrides bit layout: STATUS[8]=tx_ovf, rx_count in [23:16]).
REQ-024 RXDATA read when RX empty: dat_o = 32'h0, pointers unchanged, ack given.
REQ-025 RXDATA read dat_o = RX head word at accept edge; pop same edge.
REQ-026 Reading STATUS clears tx_ovf (cleared value returned is pre-clear value).
REQ-027 h_wr when RX full: ignored; h_rd when TX empty: ignored.
REQ-028 Simultaneous push and pop on same FIFO same cycle: both happen, count unchanged; on full FIFO pop frees slot and push proceeds; on empty FIFO push proceeds, pop ignored.
REQ-029 Pointers DEPTH_LOG2 bits wrapping modulo DEPTH; count DEPTH_LOG2+1 bits, range 0..DEPTH.
REQ-030 h_nint = !((IRQEN[0] & !rx_empty) | (IRQEN[1] & !tx_full)), registered one cycle after condition change.
REQ-031 FIFO storage need not reset; only pointers, counts, flags, registers reset.

Reset
REQ-032 On rst: ack_o=0, dat_o=0, IRQEN=0, tx_ovf=0, both FIFOs empty, h_empty=1, h_full=0, h_nint=1, h_rdat don't-care.
REQ-033 rst mid-access: access aborted, ack_o=0 immediately, FIFO contents discarded.
REQ-034 Release of rst: first access accepted on first rising edge with rst low.

Verification
REQ-035 Reset, then WB read STATUS -> dat_o=32'h00000005, ack_o one cycle after strobe; h_nint=1.
REQ-036 WB write 32'hDEADBEEF to 0x00 -> h_empty falls, h_rdat=32'hDEADBEEF; h_rd one cycle -> h_empty=1.
REQ-037 17 WB writes to TXDATA (values 1..17) -> first 16 kept, STATUS[8]=1, host pops 1..16 in order; second STATUS read shows bit 8 = 0.
REQ-038 IRQEN=1, host h_wr 32'h12345678 -> h_nint low within 2 cycles; WB read 0x04 returns 32'h12345678, h_nint returns high; further read 0x04 returns 0.
REQ-039 Fill RX to 16, same cycle h_wr and WB pop -> count stays 16, h_full stays 1, newest word read last.
REQ-040 Assert rst while ack_o pending with FIFOs half full -> ack_o=0, STATUS read after release = 32'h00000005.
